// File: rtl/div_pkg.sv
// Shared definitions for the sequential RV32M divider: op encodings, FSM states
// and special-case quotient constants.
package div_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIN
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_Q      = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic is_signed_op(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes; the compare is done
// as an XLEN+1-bit subtract so a shifted remainder above 2^XLEN-1 cannot overflow.
module div_step #(
    parameter int unsigned XLEN = div_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, q_i[XLEN-1]};
        diff    = shifted - {1'b0, dvs_i};
        // No borrow out of the top bit means shifted >= divisor.
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with start/busy/done.
// Define SEQ_DIVIDER_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module seq_divider #(
    parameter int unsigned XLEN = div_pkg::XLEN,
    parameter int unsigned ITER = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    import div_pkg::*;

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i (rem_q),
        .q_i   (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_quo)
    );

    logic            sgn_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] fin_quo;
    logic [XLEN-1:0] fin_rem;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        done_d     = 1'b0;
        sgn_op     = is_signed_op(op_q);
        a_neg      = sgn_op & dividend_q[XLEN-1];
        b_neg      = sgn_op & divisor_q[XLEN-1];
        fin_quo    = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        fin_rem    = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d       = div_op_e'(op_i);
                    dividend_d = dividend_i;
                    divisor_d  = divisor_i;
                    state_d    = PREP;
                end
            end
            PREP: begin
                quo_d     = a_neg ? (~dividend_q + 1'b1) : dividend_q;
                dvs_d     = b_neg ? (~divisor_q + 1'b1) : divisor_q;
                rem_d     = '0;
                cnt_d     = '0;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                div0_d    = (divisor_q == '0);
                ovf_d     = sgn_op && (dividend_q == OVF_Q) && (divisor_q == {XLEN{1'b1}});
                state_d   = CALC;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                if ((divisor_q == '0) ||
                    (sgn_op && (dividend_q == OVF_Q) && (divisor_q == {XLEN{1'b1}}))) begin
                    state_d = FIN;
                end
`endif
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // Special cases ignore whatever CALC left in the datapath.
                if (div0_q) begin
                    fin_quo = DIV_ZERO_Q;
                    fin_rem = dividend_q;
                end else if (ovf_q) begin
                    fin_quo = OVF_Q;
                    fin_rem = '0;
                end
                result_d = is_rem_op(op_q) ? fin_rem : fin_quo;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= OP_DIV;
            dividend_q <= '0;
            divisor_q  <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] dividend_i = 32'd0;
    logic [31:0] divisor_i = 32'd0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    seq_divider u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam int LatSpecial = 2;
`else
    localparam int LatSpecial = 34;
`endif

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int unsigned acc;
        int unsigned lat;
        logic [31:0] res;
        bit          has_lit;
        logic [31:0] lit;
    } exp_t;

    exp_t        pend[$];
    logic [31:0] held = 32'd0;

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [1:0] op, input logic [31:0] a, b);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (is_special(op, a, b)) return 2;
`endif
        return 34;
    endfunction

    function automatic bit model_busy(input int unsigned c);
        foreach (pend[i]) if (c >= pend[i].acc && c < pend[i].acc + pend[i].lat) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model queue.
    always @(negedge clk_i) begin
        bit eb;
        bit ed;
        if (rst_ni) begin
            ed = (pend.size() > 0) && (cyc == pend[0].acc + pend[0].lat);
            eb = model_busy(cyc);
            check("busy", {31'd0, busy_o}, {31'd0, eb});
            check("done", {31'd0, done_o}, {31'd0, ed});
            if (ed) begin
                check("result", result_o, pend[0].res);
                if (pend[0].has_lit) check("result_lit", result_o, pend[0].lit);
                held = pend[0].res;
                void'(pend.pop_front());
            end else begin
                check("result_held", result_o, held);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive start for the next edge; the model decides whether it is accepted.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, b,
                         input bit has_lit, input logic [31:0] lit);
        exp_t e;
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        if (!model_busy(cyc)) begin
            e.acc     = cyc + 1;
            e.lat     = model_lat(op, a, b);
            e.res     = model(op, a, b);
            e.has_lit = has_lit;
            e.lit     = lit;
            pend.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pend.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (pend.size() != 0) begin
            bad++;
            total++;
            $display("FAIL wait_idle: timeout, %0d ops pending", pend.size());
            pend.delete();
        end
    endtask

    // Returns number of clocks from the accepting edge to the done cycle.
    task automatic run_until_done(output int n);
        n = 0;
        while (!done_o && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic directed(input logic [1:0] op, input logic [31:0] a, b,
                            input logic [31:0] lit, input int exp_lat);
        int n;
        wait_idle();
        step();
        issue(op, a, b, 1'b1, lit);
        step();
        start_i = 1'b0;
        run_until_done(n);
        check("latency", n, exp_lat);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(20);
            4:       return 32'hFFFF_FFFF - $urandom_range(20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned tgt;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        rst_ni = 1'b1;
        step();

        directed(2'd1, 32'd100, 32'd7, 32'd14, 34);
        directed(2'd3, 32'd100, 32'd7, 32'd2, 34);
        directed(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        directed(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        directed(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        directed(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, LatSpecial);
        directed(2'd3, 32'd5, 32'd0, 32'd5, LatSpecial);
        directed(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LatSpecial);
        directed(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LatSpecial);

        // Start with new operands mid-operation must be dropped.
        wait_idle();
        step();
        issue(2'd1, 32'd1000, 32'd3, 1'b1, 32'd333);
        step();
        start_i = 1'b0;
        repeat (10) step();
        issue(2'd0, 32'd7, 32'd1, 1'b0, 32'd0);
        step();
        start_i    = 1'b0;
        dividend_i = 32'hDEAD_BEEF;
        divisor_i  = 32'd0;
        run_until_done(n);
        // Back-to-back start in the done cycle.
        issue(2'd3, 32'd1000, 32'd7, 1'b1, 32'd6);
        step();
        start_i = 1'b0;
        run_until_done(n);
        check("b2b_latency", n, 34);

        // Asynchronous reset in the middle of CALC.
        wait_idle();
        step();
        issue(2'd1, 32'd12345, 32'd67, 1'b0, 32'd0);
        step();
        start_i = 1'b0;
        repeat (16) step();
        #1;
        rst_ni = 1'b0;
        pend.delete();
        held = 32'd0;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        repeat (40) step();

        // Random traffic; starts while busy are ignored by the model.
        for (int i = 0; i < 1500; i++) begin
            step();
            start_i = 1'b0;
            if ($urandom_range(19) == 0)
                issue(2'($urandom_range(3)), rnd_operand(), rnd_operand(), 1'b0, 32'd0);
        end
        step();
        start_i = 1'b0;
        wait_idle();

        tgt = cyc + 5;
        while (cyc < tgt) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
